// File: rtl/arq_link_pkg.sv
// Shared definitions for the serial ARQ frame link (sender and receiver).
package arq_link_pkg;

    localparam logic [7:0]  FAS_DEFAULT           = 8'hF6;
    localparam logic [7:0]  CRC_POLY_DEFAULT      = 8'h07;
    localparam logic [7:0]  CRC_INIT              = 8'h00;
    localparam int unsigned ACK_CYCLES_DEFAULT    = 4;
    localparam int unsigned PAYLOAD_BYTES_DEFAULT = 4;

    typedef enum logic [2:0] {
        StHunt,
        StPayload,
        StCrc,
        StCheck,
        StAck
    } rx_state_e;

    // One bit of MSB-first CRC-8, no reflection.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic din,
                                             input logic [7:0] poly);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/arq_frame_receiver_if.sv
// Payload byte stream (valid/ready) from the frame receiver to the UART transmit path.
interface arq_frame_receiver_if;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       i_data_ready;

    modport master (output o_data, output o_data_valid, input i_data_ready);
    modport slave  (input o_data, input o_data_valid, output i_data_ready);
endinterface

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 register with synchronous clear and bit enable.
module crc8_serial
    import arq_link_pkg::*;
#(
    parameter logic [7:0] POLY = CRC_POLY_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_crc
);

    logic [7:0] crc_q, crc_d;

    // Clear takes priority over a shifted-in bit.
    always_comb begin
        crc_d = crc_q;
        if (i_clr) begin
            crc_d = CRC_INIT;
        end else if (i_en) begin
            crc_d = crc8_next(crc_q, i_bit, POLY);
        end
    end

    // CRC state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_crc = crc_q;

endmodule

// File: rtl/arq_frame_receiver.sv
// Serial frame receiver: FAS hunt, payload deserialise, CRC-8 check, ARQ ack and
// committed-byte drain. Define ARQ_RX_STATS_EN to add good/bad frame counters.
module arq_frame_receiver
    import arq_link_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES = PAYLOAD_BYTES_DEFAULT,
    parameter logic [7:0]  FAS           = FAS_DEFAULT,
    parameter logic [7:0]  CRC_POLY      = CRC_POLY_DEFAULT,
    parameter int unsigned ACK_CYCLES    = ACK_CYCLES_DEFAULT
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_arq_en,
    input  logic                        i_otn_tx_data,
    output logic                        o_otn_rx_ack,
    arq_frame_receiver_if.master        byte_if,
    output logic [7:0]                  o_crc_val,
    output logic                        o_crc_err,
    output logic                        o_overflow
`ifdef ARQ_RX_STATS_EN
    ,
    output logic [15:0]                 o_good_cnt,
    output logic [15:0]                 o_bad_cnt
`endif
);

    localparam int unsigned     IdxW        = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [15:0]     PayloadLast = 16'(8 * PAYLOAD_BYTES - 1);
    localparam logic [15:0]     AckLast     = 16'(ACK_CYCLES - 1);
    localparam logic [IdxW-1:0] ByteLast    = IdxW'(PAYLOAD_BYTES - 1);

    rx_state_e       state_q, state_d;
    logic [7:0]      sr_q, sr_d;
    logic [7:0]      sr_next;
    logic [15:0]     cnt_q, cnt_d;
    logic [7:0]      stage_q [PAYLOAD_BYTES];
    logic [7:0]      stage_d [PAYLOAD_BYTES];
    logic [7:0]      out_q   [PAYLOAD_BYTES];
    logic [7:0]      out_d   [PAYLOAD_BYTES];
    logic [IdxW-1:0] rd_idx_q, rd_idx_d;
    logic            busy_q, busy_d;
    logic [7:0]      crc_val_q, crc_val_d;
    logic            ovf_q, ovf_d;
    logic            crc_clr, crc_en, crc_err;
    logic            commit_req;
    logic            crc_match;
    logic [7:0]      crc_calc;

    assign sr_next   = {sr_q[6:0], i_otn_tx_data};
    // After the CRC field the shift register holds exactly the received CRC byte.
    assign crc_match = (sr_q == crc_calc);

    crc8_serial #(
        .POLY (CRC_POLY)
    ) u_crc (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (crc_clr),
        .i_en  (crc_en),
        .i_bit (i_otn_tx_data),
        .o_crc (crc_calc)
    );

    // Next-state logic for the frame FSM, staging/output buffers and drain.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_next;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        out_d      = out_q;
        rd_idx_d   = rd_idx_q;
        busy_d     = busy_q;
        crc_val_d  = crc_val_q;
        ovf_d      = ovf_q;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        crc_err    = 1'b0;
        commit_req = 1'b0;

        if (busy_q && byte_if.i_data_ready) begin
            if (rd_idx_q == ByteLast) begin
                busy_d   = 1'b0;
                rd_idx_d = '0;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end

        unique case (state_q)
            StHunt: begin
                if (sr_next == FAS) begin
                    state_d = StPayload;
                    cnt_d   = '0;
                    crc_clr = 1'b1;
                end
            end
            StPayload: begin
                crc_en = 1'b1;
                if (cnt_q[2:0] == 3'd7) begin
                    stage_d[cnt_q[3 +: IdxW]] = sr_next;
                end
                if (cnt_q == PayloadLast) begin
                    state_d = StCrc;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StCrc: begin
                if (cnt_q == 16'd7) begin
                    state_d = StCheck;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StCheck: begin
                crc_val_d  = crc_calc;
                crc_err    = !crc_match;
                commit_req = !i_arq_en || crc_match;
                state_d    = StHunt;
                if (commit_req) begin
                    if (busy_q) begin
                        // Previous frame still draining: drop this one, no ack.
                        ovf_d = 1'b1;
                    end else begin
                        out_d    = stage_q;
                        busy_d   = 1'b1;
                        rd_idx_d = '0;
                        if (i_arq_en) begin
                            state_d = StAck;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            StAck: begin
                // Line bits are ignored during the ack; hunt restarts from scratch.
                sr_d = '0;
                if (cnt_q == AckLast) begin
                    state_d = StHunt;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StHunt;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= StHunt;
            sr_q      <= '0;
            cnt_q     <= '0;
            stage_q   <= '{default: '0};
            out_q     <= '{default: '0};
            rd_idx_q  <= '0;
            busy_q    <= 1'b0;
            crc_val_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            out_q     <= out_d;
            rd_idx_q  <= rd_idx_d;
            busy_q    <= busy_d;
            crc_val_q <= crc_val_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_otn_rx_ack         = (state_q == StAck);
    assign byte_if.o_data       = out_q[rd_idx_q];
    assign byte_if.o_data_valid = busy_q;
    assign o_crc_val            = crc_val_q;
    assign o_crc_err            = crc_err;
    assign o_overflow           = ovf_q;

`ifdef ARQ_RX_STATS_EN
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] bad_cnt_q, bad_cnt_d;

    // Saturating per-frame CRC outcome counters, updated in CHECK.
    always_comb begin
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (state_q == StCheck) begin
            if (crc_match) begin
                if (good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
            end else begin
                if (bad_cnt_q != 16'hFFFF) bad_cnt_d = bad_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign o_good_cnt = good_cnt_q;
    assign o_bad_cnt  = bad_cnt_q;
`endif

endmodule

// File: tb/tb_arq_frame_receiver.sv
// Directed bench for arq_frame_receiver; inputs change and outputs are sampled on negedge.
module tb_arq_frame_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       arq_en;
    logic       tx_bit;
    logic       ack;
    logic [7:0] crc_val;
    logic       crc_err;
    logic       overflow;
`ifdef ARQ_RX_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    arq_frame_receiver_if bif ();

    arq_frame_receiver dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_arq_en      (arq_en),
        .i_otn_tx_data (tx_bit),
        .o_otn_rx_ack  (ack),
        .byte_if       (bif),
        .o_crc_val     (crc_val),
        .o_crc_err     (crc_err),
        .o_overflow    (overflow)
`ifdef ARQ_RX_STATS_EN
        ,
        .o_good_cnt    (good_cnt),
        .o_bad_cnt     (bad_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tx_bit = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        tx_bit = b;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_frame(input logic [31:0] payload, input logic [7:0] crc);
        send_byte(8'hF6);
        for (int i = 3; i >= 0; i--) send_byte(payload[8*i +: 8]);
        send_byte(crc);
    endtask

    // Good frame in ARQ mode with ready=1: ack overlaps the 4-byte drain.
    task automatic expect_good(input string tag, input logic [31:0] payload,
                               input logic [7:0] crc);
        tick();
        chk({tag, "_check_ack"}, 32'(ack), 32'd0);
        chk({tag, "_check_err"}, 32'(crc_err), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk({tag, "_ack_hi"}, 32'(ack), 32'd1);
            chk({tag, "_valid"}, 32'(bif.o_data_valid), 32'd1);
            chk({tag, "_data"}, 32'(bif.o_data), 32'(payload[8*(3-k) +: 8]));
            if (k == 0) chk({tag, "_crc_val"}, 32'(crc_val), 32'(crc));
        end
        tick();
        chk({tag, "_ack_lo"}, 32'(ack), 32'd0);
        chk({tag, "_valid_lo"}, 32'(bif.o_data_valid), 32'd0);
    endtask

    initial begin
        logic [12:0] idle_bits;
        idle_bits        = 13'b1011001110100;
        rst              = 1'b0;
        arq_en           = 1'b1;
        tx_bit           = 1'b0;
        bif.i_data_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_valid", 32'(bif.o_data_valid), 32'd0);
        chk("rst_crc_val", 32'(crc_val), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b1;

        // Clean frame.
        send_frame(32'h0000_0001, 8'h07);
        expect_good("clean", 32'h0000_0001, 8'h07);

        // Corrupt frame, ARQ on: error pulse, no ack, nothing released.
        send_frame(32'h0000_0001, 8'h06);
        tick();
        chk("bad_err", 32'(crc_err), 32'd1);
        tick();
        chk("bad_err_pulse", 32'(crc_err), 32'd0);
        chk("bad_ack", 32'(ack), 32'd0);
        chk("bad_valid", 32'(bif.o_data_valid), 32'd0);
        chk("bad_crc_val", 32'(crc_val), 32'h07);

        // Corrupt frame, ARQ off: bytes pass through, still no ack.
        arq_en = 1'b0;
        send_frame(32'h0000_0001, 8'h06);
        tick();
        chk("off_err", 32'(crc_err), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("off_ack", 32'(ack), 32'd0);
            chk("off_valid", 32'(bif.o_data_valid), 32'd1);
            chk("off_data", 32'(bif.o_data), (k == 3) ? 32'h01 : 32'h00);
        end
        tick();
        chk("off_valid_lo", 32'(bif.o_data_valid), 32'd0);
        arq_en = 1'b1;

        // Misaligned start: idle bits before the frame.
        for (int i = 12; i >= 0; i--) send_bit(idle_bits[i]);
        send_frame(32'h0000_0000, 8'h00);
        expect_good("hunt", 32'h0000_0000, 8'h00);

        // Backpressure: first frame held, second frame overflows.
        bif.i_data_ready = 1'b0;
        send_frame(32'h0000_0001, 8'h07);
        tick();
        chk("bp_check_ack", 32'(ack), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_ack_hi", 32'(ack), 32'd1);
            chk("bp_valid_hold", 32'(bif.o_data_valid), 32'd1);
            chk("bp_data_hold", 32'(bif.o_data), 32'h00);
        end
        tick();
        chk("bp_ack_lo", 32'(ack), 32'd0);
        send_frame(32'h0000_0002, 8'h0E);
        tick();
        chk("ovf_err", 32'(crc_err), 32'd0);
        chk("ovf_pre", 32'(overflow), 32'd0);
        tick();
        chk("ovf_no_ack", 32'(ack), 32'd0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_valid", 32'(bif.o_data_valid), 32'd1);
        chk("ovf_data0", 32'(bif.o_data), 32'h00);
        bif.i_data_ready = 1'b1;
        tick();
        chk("ovf_data1", 32'(bif.o_data), 32'h00);
        tick();
        chk("ovf_data2", 32'(bif.o_data), 32'h00);
        tick();
        chk("ovf_data3", 32'(bif.o_data), 32'h01);
        tick();
        chk("ovf_valid_lo", 32'(bif.o_data_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
`ifdef ARQ_RX_STATS_EN
        chk("stats_good_a", 32'(good_cnt), 32'd4);
        chk("stats_bad_a", 32'(bad_cnt), 32'd2);
`endif

        // Reset in the middle of the payload.
        send_byte(8'hF6);
        send_byte(8'h00);
        send_byte(8'hAA);
        @(negedge clk);
        rst    = 1'b0;
        tx_bit = 1'b0;
        @(negedge clk);
        chk("mrst_ack", 32'(ack), 32'd0);
        chk("mrst_valid", 32'(bif.o_data_valid), 32'd0);
        chk("mrst_data", 32'(bif.o_data), 32'd0);
        chk("mrst_crc_val", 32'(crc_val), 32'd0);
        chk("mrst_err", 32'(crc_err), 32'd0);
        chk("mrst_ovf", 32'(overflow), 32'd0);
        rst = 1'b1;
        send_frame(32'h0000_0003, 8'h09);
        expect_good("post_rst", 32'h0000_0003, 8'h09);

`ifdef ARQ_RX_STATS_EN
        send_frame(32'h0000_0001, 8'h07);
        repeat (6) tick();
        send_frame(32'h0000_0002, 8'h0E);
        repeat (6) tick();
        send_frame(32'h0000_0001, 8'h06);
        repeat (2) tick();
        send_frame(32'h0000_0003, 8'h08);
        repeat (2) tick();
        chk("stats_good", 32'(good_cnt), 32'd3);
        chk("stats_bad", 32'(bad_cnt), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
